// File: rtl/gol_frame_streamer_if.sv
// Byte-stream interface between the frame streamer and the display sink.
//   out_valid : byte on out_data is valid (source -> sink)
//   out_ready : sink accepts the byte when out_valid & out_ready (sink -> source)
//   out_data  : stream byte
//   out_last  : marks the final byte of a frame
interface gol_frame_streamer_if;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/gol_frame_streamer.sv
// gol_frame_streamer
//   Snapshots the game grid, generation and cursor on each rising edge of
//   frame_req and serialises them as a byte frame:
//     A5, gen[15:8], gen[7:0], GRID_W*GRID_H cell bytes (row-major), 5A(last)
//   A request arriving mid-frame is held 1-deep and launched after the tail.
// Ports
//   clk, reset       : clock, asynchronous active-high reset
//   frame_req        : update strobe (level, edge-detected internally)
//   grid_in          : cell (x,y) at bit y*GRID_W+x, 1 = alive
//   generation       : generation count
//   selectedx/y      : cursor position
//   paused           : cursor is only drawn while paused
//   out_if           : valid/ready byte stream (master)
//   busy             : frame in progress
//   frames_sent      : completed frames, wrapping
// Configuration
//   GOL_CURSOR_OVERLAY_EN : when defined, bit7 of the cursor cell byte is set
//   (only while paused). When undefined the cursor inputs are ignored.
module gol_frame_streamer #(
  parameter int unsigned GRID_W  = 16,
  parameter int unsigned GRID_H  = 16,
  parameter int unsigned COORD_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       frame_req,
  input  logic [GRID_W*GRID_H-1:0]   grid_in,
  input  logic [15:0]                generation,
  input  logic [COORD_W-1:0]         selectedx,
  input  logic [COORD_W-1:0]         selectedy,
  input  logic                       paused,
  gol_frame_streamer_if.master       out_if,
  output logic                       busy,
  output logic [15:0]                frames_sent
);

  localparam int unsigned N_CELLS = GRID_W * GRID_H;
  localparam int unsigned IDX_W   = $clog2(N_CELLS) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CELLS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR0,
    S_HDR1,
    S_HDR2,
    S_CELLS,
    S_TAIL
  } state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 pending_q, pending_d;
  logic                 launch_q, launch_d;
  logic                 req_q, req_d;
  logic                 req_prev_q, req_prev_d;
  logic [15:0]          frames_sent_q, frames_sent_d;
  logic [N_CELLS-1:0]   grid_snap_q, grid_snap_d;
  logic [15:0]          gen_snap_q, gen_snap_d;
  logic                 out_valid_q, out_valid_d;
  logic [7:0]           out_data_q, out_data_d;
  logic                 out_last_q, out_last_d;
  logic                 busy_q, busy_d;

  logic                 rise_c;
  logic                 accept_c;
  logic                 take_snap_c;
  logic                 cursor_hit_c;

`ifdef GOL_CURSOR_OVERLAY_EN
  logic [COORD_W-1:0]   snap_selx_q, snap_selx_d;
  logic [COORD_W-1:0]   snap_sely_q, snap_sely_d;
  logic                 snap_paused_q, snap_paused_d;
  logic [IDX_W-1:0]     cursor_idx_c;
`endif

  // Request is registered once before edge detection.
  assign req_d      = frame_req;
  assign req_prev_d = req_q;
  assign rise_c     = req_q & ~req_prev_q;
  assign accept_c   = out_valid_q & out_if.out_ready;

  // Next-state, index, pending and snapshot logic.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    pending_d     = pending_q;
    launch_d      = 1'b0;
    frames_sent_d = frames_sent_q;
    grid_snap_d   = grid_snap_q;
    gen_snap_d    = gen_snap_q;
    take_snap_c   = 1'b0;
`ifdef GOL_CURSOR_OVERLAY_EN
    snap_selx_d   = snap_selx_q;
    snap_sely_d   = snap_sely_q;
    snap_paused_d = snap_paused_q;
`endif

    // Any request that arrives while a frame is running is held 1-deep.
    if (rise_c && (state_q != S_IDLE)) pending_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (launch_q) begin
          // Snapshot for this frame was taken when the previous tail left.
          state_d = S_HDR0;
          if (rise_c) pending_d = 1'b1;
        end else if (rise_c) begin
          take_snap_c = 1'b1;
          state_d     = S_HDR0;
        end
      end
      S_HDR0: if (accept_c) state_d = S_HDR1;
      S_HDR1: if (accept_c) state_d = S_HDR2;
      S_HDR2: begin
        if (accept_c) begin
          state_d = S_CELLS;
          idx_d   = '0;
        end
      end
      S_CELLS: begin
        if (accept_c) begin
          if (idx_q == LAST_IDX) state_d = S_TAIL;
          else                   idx_d   = idx_q + IDX_W'(1);
        end
      end
      S_TAIL: begin
        if (accept_c) begin
          frames_sent_d = frames_sent_q + 16'd1;
          state_d       = S_IDLE;
          if (pending_q || rise_c) begin
            take_snap_c = 1'b1;
            pending_d   = 1'b0;
            launch_d    = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (take_snap_c) begin
      grid_snap_d = grid_in;
      gen_snap_d  = generation;
`ifdef GOL_CURSOR_OVERLAY_EN
      snap_selx_d   = selectedx;
      snap_sely_d   = selectedy;
      snap_paused_d = paused;
`endif
    end
  end

`ifdef GOL_CURSOR_OVERLAY_EN
  // Cursor flag for the cell about to be presented; off-grid cursors match nothing.
  always_comb begin
    cursor_idx_c = IDX_W'(snap_sely_d) * IDX_W'(GRID_W) + IDX_W'(snap_selx_d);
    cursor_hit_c = 1'b0;
    if (snap_paused_d && (snap_selx_d < COORD_W'(GRID_W)) && (snap_sely_d < COORD_W'(GRID_H)))
      cursor_hit_c = (idx_d == cursor_idx_c);
  end
`else
  logic unused_cursor_c;
  assign unused_cursor_c = ^{selectedx, selectedy, paused};
  assign cursor_hit_c    = 1'b0;
`endif

  // Output byte follows the next state, so it only changes on acceptance.
  always_comb begin
    out_valid_d = (state_d != S_IDLE);
    out_last_d  = (state_d == S_TAIL);
    busy_d      = (state_d != S_IDLE);
    out_data_d  = 8'h00;
    case (state_d)
      S_HDR0:  out_data_d = 8'hA5;
      S_HDR1:  out_data_d = gen_snap_d[15:8];
      S_HDR2:  out_data_d = gen_snap_d[7:0];
      S_CELLS: out_data_d = {cursor_hit_c, 6'b000000, grid_snap_d[idx_d[IDX_W-2:0]]};
      S_TAIL:  out_data_d = 8'h5A;
      default: out_data_d = 8'h00;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      pending_q     <= 1'b0;
      launch_q      <= 1'b0;
      req_q         <= 1'b0;
      req_prev_q    <= 1'b0;
      frames_sent_q <= '0;
      grid_snap_q   <= '0;
      gen_snap_q    <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_last_q    <= 1'b0;
      busy_q        <= 1'b0;
`ifdef GOL_CURSOR_OVERLAY_EN
      snap_selx_q   <= '0;
      snap_sely_q   <= '0;
      snap_paused_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      pending_q     <= pending_d;
      launch_q      <= launch_d;
      req_q         <= req_d;
      req_prev_q    <= req_prev_d;
      frames_sent_q <= frames_sent_d;
      grid_snap_q   <= grid_snap_d;
      gen_snap_q    <= gen_snap_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_last_q    <= out_last_d;
      busy_q        <= busy_d;
`ifdef GOL_CURSOR_OVERLAY_EN
      snap_selx_q   <= snap_selx_d;
      snap_sely_q   <= snap_sely_d;
      snap_paused_q <= snap_paused_d;
`endif
    end
  end

  assign out_if.out_valid = out_valid_q;
  assign out_if.out_data  = out_data_q;
  assign out_if.out_last  = out_last_q;
  assign busy             = busy_q;
  assign frames_sent      = frames_sent_q;

endmodule

// File: tb/tb_gol_frame_streamer.sv
// Testbench for gol_frame_streamer: randomized frames against a reference
// frame builder, scoreboard queue drained by a negedge monitor.
module tb_gol_frame_streamer;

  localparam int unsigned GW = 16;
  localparam int unsigned GH = 16;
  localparam int unsigned CW = 8;
  localparam int unsigned NC = GW * GH;
`ifdef GOL_CURSOR_OVERLAY_EN
  localparam bit CURSOR_ON = 1'b1;
`else
  localparam bit CURSOR_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          frame_req;
  logic [NC-1:0] grid;
  logic [15:0]   gen;
  logic [CW-1:0] selx, sely;
  logic          paused_i;
  logic          busy;
  logic [15:0]   frames_sent;

  gol_frame_streamer_if sif ();

  gol_frame_streamer #(.GRID_W(GW), .GRID_H(GH), .COORD_W(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_req   (frame_req),
    .grid_in     (grid),
    .generation  (gen),
    .selectedx   (selx),
    .selectedy   (sely),
    .paused      (paused_i),
    .out_if      (sif),
    .busy        (busy),
    .frames_sent (frames_sent)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [8:0]  exp_q[$];
  logic [15:0] exp_frames = 16'd0;
  int          rdy_mode = 0;
  int          ncyc = 0;
  int          tail_cyc = 0;
  int          last_gap = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference frame: header, row-major cells, tail.
  task automatic push_frame(input logic [NC-1:0] g, input logic [15:0] gv,
                            input logic [CW-1:0] sx, input logic [CW-1:0] sy, input logic p);
    logic [7:0] b;
    exp_q.push_back({1'b0, 8'hA5});
    exp_q.push_back({1'b0, gv[15:8]});
    exp_q.push_back({1'b0, gv[7:0]});
    for (int y = 0; y < int'(GH); y++) begin
      for (int x = 0; x < int'(GW); x++) begin
        b = {7'd0, g[y*GW + x]};
        if (CURSOR_ON && p && (x == int'(sx)) && (y == int'(sy))) b[7] = 1'b1;
        exp_q.push_back({1'b0, b});
      end
    end
    exp_q.push_back({1'b1, 8'h5A});
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < int'(NC / 32); i++) grid[i*32 +: 32] = $urandom();
    gen      = 16'($urandom());
    selx     = CW'($urandom_range(0, 17));
    sely     = CW'($urandom_range(0, 17));
    paused_i = 1'($urandom_range(0, 1));
  endtask

  // Launch a frame from idle and check the request-to-first-byte latency.
  task automatic start_frame();
    push_frame(grid, gen, selx, sely, paused_i);
    frame_req = 1'b1;
    tick();
    frame_req = 1'b0;
    check("lat_early_valid", 32'(sif.out_valid), 32'd0);
    tick();
    check("lat_valid", 32'(sif.out_valid), 32'd1);
    check("lat_hdr", 32'(sif.out_data), 32'hA5);
    check("busy_on", 32'(busy), 32'd1);
  endtask

  task automatic pulse();
    frame_req = 1'b1;
    tick();
    frame_req = 1'b0;
    tick();
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: got %0d bytes left, want 0", name, exp_q.size());
    end
    check({name, "_frames"}, 32'(frames_sent), 32'(exp_frames));
    check({name, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Ready pattern driver.
  initial begin
    int c = 0;
    sif.out_ready = 1'b1;
    forever begin
      tick();
      c++;
      case (rdy_mode)
        0:       sif.out_ready = 1'b1;
        1:       if (c % 3 == 0) sif.out_ready = ~sif.out_ready;
        default: sif.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops the scoreboard on each accepted byte, checks stall stability
  // and that valid never drops inside a frame.
  initial begin
    logic       stall = 1'b0;
    logic       in_frame = 1'b0;
    logic [8:0] held = '0;
    logic [8:0] e;
    forever begin
      @(negedge clk);
      ncyc++;
      if (reset) begin
        stall    = 1'b0;
        in_frame = 1'b0;
      end else begin
        if (stall && sif.out_valid)
          check("stall_hold", 32'({sif.out_last, sif.out_data}), 32'(held));
        if (in_frame) check("no_bubble", 32'(sif.out_valid), 32'd1);
        stall = sif.out_valid && !sif.out_ready;
        held  = {sif.out_last, sif.out_data};
        if (sif.out_valid && sif.out_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_byte: got 0x%0h, want no byte", sif.out_data);
          end else begin
            e = exp_q.pop_front();
            check("byte", 32'({sif.out_last, sif.out_data}), 32'(e));
            if (!in_frame) last_gap = ncyc - tail_cyc;
            if (e[8]) begin
              in_frame = 1'b0;
              tail_cyc = ncyc;
              exp_frames = exp_frames + 16'd1;
            end else begin
              in_frame = 1'b1;
            end
          end
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    reset = 1'b1;
    frame_req = 1'b0;
    grid = '0;
    gen = '0;
    selx = '0;
    sely = '0;
    paused_i = 1'b0;
    repeat (3) tick();
    check("rst_valid", 32'(sif.out_valid), 32'd0);
    check("rst_data", 32'(sif.out_data), 32'd0);
    check("rst_last", 32'(sif.out_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frames", 32'(frames_sent), 32'd0);
    reset = 1'b0;
    repeat (2) tick();

    // Basic frame: single live cell at (1,0).
    grid = '0;
    grid[1] = 1'b1;
    gen = 16'h0102;
    start_frame();
    wait_drain("basic");

    // Cursor on the last cell, paused then running.
    rand_inputs();
    grid[NC-1] = 1'b1;
    selx = CW'(15);
    sely = CW'(15);
    paused_i = 1'b1;
    start_frame();
    wait_drain("cursor_paused");
    paused_i = 1'b0;
    start_frame();
    wait_drain("cursor_running");

    // Backpressure with the grid changing mid-frame.
    rdy_mode = 1;
    rand_inputs();
    start_frame();
    begin
      int n = 0;
      while (exp_q.size() > 150 && n < 2000) begin
        tick();
        n++;
      end
    end
    rand_inputs();
    wait_drain("backpressure");

    // Random frames under random ready.
    rdy_mode = 2;
    for (int i = 0; i < 6; i++) begin
      rand_inputs();
      start_frame();
      repeat ($urandom_range(5, 60)) tick();
      rand_inputs();
      wait_drain("random");
    end

    // Pending: two extra requests mid-frame yield exactly one more frame.
    rdy_mode = 0;
    repeat (3) tick();
    f0 = int'(frames_sent);
    rand_inputs();
    start_frame();
    repeat (20) tick();
    rand_inputs();
    push_frame(grid, gen, selx, sely, paused_i);
    pulse();
    repeat (5) tick();
    pulse();
    wait_drain("pending");
    check("pending_count", 32'(frames_sent), 32'(16'(f0 + 2)));
    check("restart_gap_ok", 32'(last_gap <= 2), 32'd1);
    repeat (300) tick();
    check("pending_idle", 32'(sif.out_valid), 32'd0);

    // Reset in the middle of a frame aborts it.
    rand_inputs();
    start_frame();
    repeat (30) tick();
    reset = 1'b1;
    #1;
    check("midrst_valid", 32'(sif.out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_frames", 32'(frames_sent), 32'd0);
    exp_q.delete();
    exp_frames = 16'd0;
    repeat (3) tick();
    reset = 1'b0;
    repeat (2) tick();
    check("postrst_idle", 32'(sif.out_valid), 32'd0);
    rand_inputs();
    start_frame();
    wait_drain("postrst");

    // Counter wrap.
    force dut.frames_sent_q = 16'hFFFF;
    tick();
    release dut.frames_sent_q;
    exp_frames = 16'hFFFF;
    rand_inputs();
    start_frame();
    wait_drain("wrap");
    check("wrap_zero", 32'(frames_sent), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
